// File: rtl/plot_sink_pkg.sv
// Plot entry type and framebuffer address helper for plot_sink.
package plot_sink_pkg;

  import vga_pkg::*;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [COLOUR_W-1:0]  colour;
  } plot_entry_t;

  // y*160 + x without a multiplier: 160 = 128 + 32.
  function automatic logic [FB_ADDR_W-1:0] fbAddr(input logic [7:0] x, input logic [6:0] y);
    logic [FB_ADDR_W-1:0] yw;
    yw = FB_ADDR_W'(y);
    return (yw << 7) + (yw << 5) + FB_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/vga_pkg.sv
// Screen geometry and framebuffer widths shared by the VGA plotting blocks.
package vga_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int FB_ADDR_W = 15;
  localparam int COLOUR_W  = 3;

endpackage

// File: rtl/plot_sink_if.sv
// Push/pop bundle between the plot_sink front end (master) and its FIFO (slave).
interface plot_sink_if #(parameter int DEPTH = 4);

  import plot_sink_pkg::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             push;
  plot_entry_t      wdata;
  logic             pop;
  plot_entry_t      head;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;

  modport master (output push, wdata, pop, input head, full, empty, level);
  modport slave  (input push, wdata, pop, output head, full, empty, level);

endinterface

// File: rtl/plot_sink_fifo.sv
// plot_fifo: power-of-two circular buffer of plot entries with occupancy count.
module plot_fifo
  import plot_sink_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       rst_n,
  plot_sink_if.slave f
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  plot_entry_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign f.full  = (r_level == LVL_W'(DEPTH));
  assign f.empty = (r_level == '0);
  assign w_pop   = f.pop && !f.empty;
  assign w_push  = f.push && (!f.full || w_pop);
  assign f.head  = r_mem[r_rd_ptr];
  assign f.level = r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= f.wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LVL_W'(1);
      end
    end
  end

endmodule

// File: rtl/plot_sink.sv
// plot_sink: clips plot strobes, converts to framebuffer addresses and buffers them.
// Optional drop counter enabled by defining PLOT_SINK_DROP_COUNT_EN.
module plot_sink
  import vga_pkg::*;
  import plot_sink_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [7:0]                   x,
  input  logic [6:0]                   y,
  input  logic [COLOUR_W-1:0]          colour,
  input  logic                         writeEn,
  output logic [FB_ADDR_W-1:0]         mem_addr,
  output logic [COLOUR_W-1:0]          mem_data,
  output logic                         mem_we,
  input  logic                         mem_ready,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  level
`ifdef PLOT_SINK_DROP_COUNT_EN
  ,
  output logic [7:0]                   drop_count
`endif
);

  plot_sink_if #(.DEPTH(FIFO_DEPTH)) fifo_bus ();

  logic w_in_range;
  logic w_push;
  logic w_pop;
  logic w_drop_full;
  logic r_overflow;

  assign w_in_range  = (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
  assign w_push      = writeEn && w_in_range;
  assign w_pop       = !fifo_bus.empty && mem_ready;
  assign w_drop_full = w_push && fifo_bus.full && !w_pop;

  assign fifo_bus.push  = w_push;
  assign fifo_bus.wdata = '{addr: fbAddr(x, y), colour: colour};
  assign fifo_bus.pop   = w_pop;

  assign mem_addr = fifo_bus.head.addr;
  assign mem_data = fifo_bus.head.colour;
  assign mem_we   = !fifo_bus.empty;
  assign level    = fifo_bus.level;
  assign overflow = r_overflow;

  plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (resetn),
    .f     (fifo_bus)
  );

  // Sticky until reset; clipped strobes never count as overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow <= 1'b0;
    end else if (w_drop_full) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef PLOT_SINK_DROP_COUNT_EN
  logic [7:0] r_drop_count;

  assign drop_count = r_drop_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_drop_count <= '0;
    end else if (writeEn && (!w_in_range || w_drop_full) && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'd1;
    end
  end
`endif

endmodule
